// File: rtl/uart_pkg.sv
// Shared UART definitions: rate defaults, bit-period derivation, parity encodings, rx states.
package uart_pkg;

  localparam int unsigned DEF_BASE_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUDRATE  = 115_200;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int unsigned counts_per_bit(input int unsigned base_freq,
                                                 input int unsigned baudrate);
    return base_freq / baudrate;
  endfunction

  localparam int unsigned DEF_COUNTS_PER_BIT = counts_per_bit(DEF_BASE_FREQ, DEF_BAUDRATE);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period cycle counter; half_tick marks the start-bit centre, full_tick each following bit centre.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned COUNTS_PER_BIT = DEF_COUNTS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned HALF_BIT = COUNTS_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(COUNTS_PER_BIT);

  logic [CW-1:0] cnt;

  // Ticks are not gated by clear: the owner asserts clear in response to a tick.
  assign half_tick = enable && (cnt == CW'(HALF_BIT - 1));
  assign full_tick = enable && (cnt == CW'(COUNTS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (full_tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling, optional odd/even parity, stop check.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BASE_FREQ = DEF_BASE_FREQ,
  parameter int unsigned BAUDRATE  = DEF_BAUDRATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_data_in,
  input  logic [1:0] parity_type,
  output logic [7:0] parallel_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned COUNTS_PER_BIT = counts_per_bit(BASE_FREQ, BAUDRATE);

  logic       rx_meta, rxs, rxs_d;
  logic       fall;
  rx_state_t  state, state_nxt;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [1:0] p_sel;
  logic       mismatch;
  logic       par_on, par_exp;
  logic       tmr_clear, half_tick, full_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= serial_data_in;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall    = rxs_d & ~rxs;
  assign par_on  = (p_sel == PAR_ODD) || (p_sel == PAR_EVEN);
  assign par_exp = (p_sel == PAR_ODD) ? ~(^shift) : ^shift;
  assign busy    = (state != RX_IDLE);

  uart_bit_timer #(
    .COUNTS_PER_BIT(COUNTS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (busy),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_clear = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          tmr_clear = 1'b1;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (half_tick) begin
          if (!rxs) begin
            tmr_clear = 1'b1;
            state_nxt = RX_DATA;
          end else begin
            state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (full_tick && (bit_idx == 3'd7)) state_nxt = par_on ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (full_tick) state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (full_tick) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Outputs are registered on the stop-sample edge, so they appear together with IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift         <= '0;
      bit_idx       <= '0;
      p_sel         <= PAR_NONE;
      mismatch      <= 1'b0;
      parallel_out  <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            p_sel    <= parity_type;
            mismatch <= 1'b0;
            bit_idx  <= '0;
          end
        end
        RX_START: begin
          if (half_tick) bit_idx <= '0;
        end
        RX_DATA: begin
          if (full_tick) begin
            shift <= {rxs, shift[7:1]};
            if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
          end
        end
        RX_PARITY: begin
          if (full_tick) mismatch <= (rxs != par_exp);
        end
        RX_STOP: begin
          if (full_tick) begin
            parallel_out  <= shift;
            parity_error  <= mismatch & par_on;
            framing_error <= ~rxs;
            data_valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a queue scoreboard checked on each data_valid.
module tb_uart_rx_frame;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_data_in;
  logic [1:0] parity_type;
  logic [7:0] parallel_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     checks   = 0;
  int     failures = 0;
  int     valids   = 0;
  int     pushes   = 0;
  longint cyc      = 0;
  longint valid_cyc = 0;
  longint start_cyc = 0;
  longint lat;

  uart_rx_frame #(
    .BASE_FREQ(50_000_000),
    .BAUDRATE (115_200)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_data_in(serial_data_in),
    .parity_type   (parity_type),
    .parallel_out  (parallel_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valids++;
      valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_valid got=%h exp=none", parallel_out);
      end else begin
        e = sb.pop_front();
        check("data", parallel_out, e.data);
        check("parity_error", {7'd0, parity_error}, {7'd0, e.perr});
        check("framing_error", {7'd0, framing_error}, {7'd0, e.ferr});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pbit,
                            input logic stop_bit, input logic exp_perr);
    exp_t x;
    x.data = d;
    x.perr = exp_perr;
    x.ferr = ~stop_bit;
    sb.push_back(x);
    pushes++;
    parity_type    = pt;
    serial_data_in = 1'b0;
    start_cyc      = cyc;
    wait_cycles(CPB);
    parity_type = 2'd3;  // must be ignored mid-frame
    for (int i = 0; i < 8; i++) begin
      serial_data_in = d[i];
      wait_cycles(CPB);
    end
    if (pt == 2'd1 || pt == 2'd2) begin
      serial_data_in = pbit;
      wait_cycles(CPB);
    end
    serial_data_in = stop_bit;
    wait_cycles(CPB);
    serial_data_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    serial_data_in = 1'b1;
    parity_type    = 2'd0;
    @(posedge clk);
    #1;
    wait_cycles(3);
    check("rst_data", parallel_out, 8'h00);
    check("rst_valid", {7'd0, data_valid}, 8'h00);
    check("rst_perr", {7'd0, parity_error}, 8'h00);
    check("rst_ferr", {7'd0, framing_error}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    wait_cycles(20);

    send_frame(8'hA5, 2'd0, 1'b0, 1'b1, 1'b0);
    lat = valid_cyc - start_cyc;
    checks++;
    assert (lat >= 4124 && lat <= 4128) else begin
      failures++;
      $error("FAIL latency_noparity got=%0d exp=4126", lat);
    end
    wait_cycles(20);

    send_frame(8'hAA, 2'd2, 1'b0, 1'b1, 1'b0);
    lat = valid_cyc - start_cyc;
    checks++;
    assert (lat >= 4558 && lat <= 4562) else begin
      failures++;
      $error("FAIL latency_parity got=%0d exp=4560", lat);
    end
    wait_cycles(20);
    send_frame(8'hAB, 2'd2, 1'b0, 1'b1, 1'b1);
    wait_cycles(20);
    send_frame(8'hAB, 2'd1, 1'b0, 1'b1, 1'b0);
    wait_cycles(20);
    send_frame(8'hAA, 2'd1, 1'b0, 1'b1, 1'b1);
    wait_cycles(20);
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_cycles(20);
    check("ferr_held", {7'd0, framing_error}, 8'h01);
    send_frame(8'h01, 2'd0, 1'b0, 1'b1, 1'b0);
    wait_cycles(20);

    // Short low glitch on an idle line
    serial_data_in = 1'b0;
    wait_cycles(100);
    serial_data_in = 1'b1;
    check("glitch_busy", {7'd0, busy}, 8'h01);
    wait_cycles(122);
    check("glitch_idle", {7'd0, busy}, 8'h00);
    wait_cycles(300);

    // Reset in the middle of data bit 4
    parity_type    = 2'd0;
    serial_data_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_data_in = 1'b1;
      wait_cycles(CPB);
    end
    wait_cycles(200);
    check("pre_abort_busy", {7'd0, busy}, 8'h01);
    rst            = 1'b1;
    serial_data_in = 1'b1;
    #1;
    check("abort_data", parallel_out, 8'h00);
    check("abort_valid", {7'd0, data_valid}, 8'h00);
    check("abort_busy", {7'd0, busy}, 8'h00);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(600);

    send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 1'b0);
    wait_cycles(20);
    send_frame(8'h11, 2'd0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 2'd0, 1'b0, 1'b1, 1'b0);
    wait_cycles(50);

    check("valid_count", 8'(valids), 8'(pushes));
    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial-to-parallel UART receiver: the receive end of the 8-bit UART link whose transmitter drives serial_out. It synchronises the asynchronous line, detects the start bit and samples each bit at mid-bit. It checks optional odd/even parity and the stop bit, then presents the byte with a one-cycle valid strobe and sticky-per-frame error flags. It sits between the board RX pin (or the looped-back TX line) and the display/LED logic in the uart top.

Parameters:
BASE_FREQ, 50_000_000, system clock frequency in Hz
BAUDRATE, 115_200, line bit rate in bit/s
COUNTS_PER_BIT, BASE_FREQ/BAUDRATE (434), clock cycles per bit (derived localparam)
HALF_BIT, COUNTS_PER_BIT/2 (217), cycles from start edge to start-bit centre (derived localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
serial_data_in  input  1  asynchronous UART line, idle high
parity_type  input  2  0 = none, 1 = odd, 2 = even, 3 = none
parallel_out  output  8  last received byte, LSB received first
data_valid  output  1  one-cycle pulse when parallel_out and flags update
parity_error  output  1  parity mismatch on last frame
framing_error  output  1  stop bit sampled low on last frame
busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: parallel_out = 0, data_valid = 0, parity_error = 0, framing_error = 0, busy = 0, state = IDLE, bit counter = 0, synchroniser flops = 1.
- Reset mid-frame: the frame is aborted immediately and no data_valid is produced.
- Synchroniser: 2-FF on serial_data_in; all logic uses the 2nd-stage output rxs. Falling-edge detect uses rxs and its registered copy.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a falling edge of rxs, clear the cycle counter, latch parity_type into p_sel, and go to START.
  - p_sel is held for the whole frame; parity_type changes mid-frame are ignored.
- START:
  - Count to HALF_BIT-1, then sample rxs.
  - If rxs = 0, go to DATA with bit index 0 and the counter cleared.
  - If rxs = 1, treat as a glitch and return to IDLE with no output change.
- DATA:
  - Sample every COUNTS_PER_BIT cycles and shift in LSB-first.
  - After bit index 7, go to PARITY if p_sel is 1 or 2, else go to STOP.
- PARITY:
  - Sample after COUNTS_PER_BIT.
  - Expected bit: even = XOR of the 8 data bits; odd = its inverse.
  - Store mismatch internally, then go to STOP.
- STOP:
  - Sample after COUNTS_PER_BIT.
  - Next cycle: parallel_out <= shift register; parity_error <= mismatch (0 when no parity); framing_error <= ~stop_sample; data_valid = 1 for exactly that cycle.
  - Return to IDLE the same cycle, so a back-to-back start edge one bit later is caught.
- Timing: t0 = the cycle the falling edge is seen on rxs.
  - Data bit i sampled at t0 + HALF_BIT + (i+1)·COUNTS_PER_BIT.
  - Stop bit sampled at t0 + HALF_BIT + 9·CPB (no parity) or + 10·CPB (with parity).
  - data_valid follows one cycle after the stop sample.
- Frame errors: parallel_out still updates and data_valid still pulses; flags flag the frame and do not suppress it.
- Flags hold until the next data_valid.
- Counter: a 9-bit cycle counter is sufficient for 434; size it with $clog2(COUNTS_PER_BIT). The bit index is 3 bits and never wraps past 7.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2
  - rx state enum
  - BASE_FREQ/BAUDRATE defaults and the COUNTS_PER_BIT derivation, shared with the transmitter
- One sub-module: uart_bit_timer.
  - Inputs: clear, enable.
  - Outputs: half_tick and full_tick pulses from the cycle counter.
  - The transmitter reuses it.

Test Plan:
- Send 0xA5, no parity (10 bit-times at 8680 ns/bit) -> one data_valid; parallel_out = 8'hA5; parity_error = 0; framing_error = 0.
- Send 0xAA, even parity, parity bit 0 -> parallel_out = 8'hAA, parity_error = 0. Send 0xAB, even parity, forced parity bit 0 -> parallel_out = 8'hAB, parity_error = 1.
- Send 0xAB, odd parity, bit 0 -> parity_error = 0. Send 0xAA, odd parity, forced bit 0 -> parity_error = 1.
- Send 0x3C with the stop bit forced low -> data_valid pulses; parallel_out = 8'h3C; framing_error = 1. Next clean frame 0x01 clears framing_error to 0.
- Drive a 100-cycle low glitch on the idle line -> no data_valid; busy returns to 0 by cycle t0 + 218.
- Assert rst during data bit 4 of a frame, then send 0x5A -> outputs return to 0 immediately; no data_valid for the aborted frame; 0x5A then received correctly. Also send two frames back-to-back (0x11, 0x22) -> two data_valid pulses with the correct bytes.
